ram_loader: RTL
===============

Name: ram_loader

Overview:
Initiator side of the CPU RAM port. It fills the 16x8 program RAM from an external byte stream while the CPU is held off the bus, then reads the RAM back to verify the image. It drives the same ADDR/DIN/RI write interface the CPU uses and consumes the RAM read data. BUSY is the top-level mux select and the CPU halt request.

Parameters:
DEPTH, 16, number of RAM words; must equal 2**ADDR_W
ADDR_W, 4, RAM address width
DATA_W, 8, RAM data width and stream byte width

Ports:
CLK  input  1  system clock, all logic on rising edge
RESET  input  1  synchronous, active-high reset
START  input  1  one-cycle request to begin a load
IN_DATA  input  DATA_W  stream byte
IN_VALID  input  1  stream byte valid
IN_READY  output  1  loader accepts byte this cycle
RAM_ADDR  output  ADDR_W  RAM address
RAM_DIN  output  DATA_W  RAM write data
RAM_RI  output  1  RAM write enable; RAM samples it on the rising edge
RAM_DOUT  input  DATA_W  RAM read data, valid one cycle after RAM_ADDR is presented
BUSY  output  1  load or verify in progress; CPU halted and RAM bus owned by loader
DONE  output  1  image loaded and verified
ERR  output  2  00 none, 01 stream checksum mismatch, 10 readback mismatch

Behaviour:
- Reset values: IN_READY=0, RAM_RI=0, RAM_ADDR=0, RAM_DIN=0, BUSY=0, DONE=0, ERR=00. The FSM goes to IDLE and the counters and sums clear.
- RAM_RI is gated by ~RESET. No write occurs in any cycle where RESET=1.
- A byte is accepted when IN_VALID & IN_READY are both 1 at a rising edge.
- FSM states: IDLE, LOAD, CHECK, VERIFY, DONE, FAIL. BUSY=1 in LOAD, CHECK and VERIFY only.
- IDLE: START=1 -> LOAD. On entry, clear wcnt, sum, ERR and DONE.
- LOAD:
  - IN_READY=1; RAM_ADDR=wcnt; RAM_DIN=IN_DATA.
  - RAM_RI = IN_VALID (combinational; the write happens in the same cycle as the accept).
  - On each accept: sum += IN_DATA (mod 256), wcnt++.
  - The accept with wcnt==DEPTH-1 moves to CHECK.
- CHECK:
  - IN_READY=1, RAM_RI=0, RAM_DIN=0.
  - The next accepted byte is the checksum.
  - If (sum + byte) mod 256 == 0 -> VERIFY; else -> FAIL with ERR=01.
- VERIFY:
  - Cycles v=0..DEPTH-1 drive RAM_ADDR=v; IN_READY=0, RAM_RI=0.
  - Data for address v is added to rsum in cycle v+1.
  - The state lasts exactly DEPTH+1 cycles.
  - After the last add: rsum==sum -> DONE; else -> FAIL with ERR=10.
- DONE: DONE=1, BUSY=0, RAM_ADDR=0. Holds until START or RESET.
- FAIL: ERR held, DONE=0, BUSY=0. Holds until START or RESET.
- START in LOAD, CHECK or VERIFY is ignored.
- START in DONE or FAIL restarts as from IDLE. DONE and ERR clear on the cycle after START.
- Reset mid-operation: abort immediately. RAM contents are partial and undefined; the RAM is not cleared.
- IN_VALID outside LOAD/CHECK is ignored; no write, no sum update.
- wcnt and the VERIFY counter are ADDR_W+1 bits wide, so there is no wrap.
- sum and rsum are DATA_W-bit modulo accumulators.

Decomposition:
- Shared package be8_pkg holds:
  - state encoding (IDLE..FAIL)
  - ERR codes ERR_NONE=2'b00, ERR_CSUM=2'b01, ERR_RDBK=2'b10
  - RAM_DEPTH=16, RAM_ADDR_W=4, DATA_W=8
- One sub-module, ram_loader_acc: DATA_W modulo accumulator with clear/add/value ports. Instantiate it twice, for sum and rsum.

Test Plan:
1. Reset, START, stream 0x00..0x0F then 0x88 -> 16 RAM_RI pulses at addresses 0..15 with data = address; VERIFY lasts 17 cycles; then DONE=1, ERR=00, BUSY=0; the RAM model holds addr i = i.
2. Same stream with checksum 0x00 -> cycle after the checksum accept: FAIL, ERR=01, DONE=0, BUSY=0, no VERIFY reads.
3. Valid stream (case 1), RAM model forces addr 5 read as 0x04 -> ERR=10 after 17 VERIFY cycles, DONE=0.
4. IN_VALID asserted every 3rd cycle with case 1 data -> RAM_RI high only on accept cycles; final result identical to case 1.
5. RESET asserted during the cycle the 8th byte is offered -> no write that cycle; next cycle all outputs at reset values; a new START with case 1 data completes with DONE=1.
6. START pulsed mid-LOAD -> ignored, load completes normally; START in DONE -> DONE=0 next cycle, BUSY=1, wcnt restarts at 0.

Source files
------------

// File: rtl/be8_pkg.sv
// Shared definitions for the RAM loader: state encoding, error codes and
// default RAM geometry.
package be8_pkg;

    localparam int RAM_DEPTH  = 16;
    localparam int RAM_ADDR_W = 4;
    localparam int DATA_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CHECK  = 3'd2,
        ST_VERIFY = 3'd3,
        ST_DONE   = 3'd4,
        ST_FAIL   = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_CSUM = 2'b01;
    localparam logic [1:0] ERR_RDBK = 2'b10;

endpackage

// File: rtl/ram_loader_acc.sv
// Modulo 2**DATA_W accumulator.
// Ports:
//   CLK, RESET  - clock, synchronous active-high reset
//   clr         - zero the accumulator (wins over add)
//   add         - add add_val this cycle
//   add_val     - value to add
//   value       - current accumulated value
module ram_loader_acc #(
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              clr,
    input  logic              add,
    input  logic [DATA_W-1:0] add_val,
    output logic [DATA_W-1:0] value
);

    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (add) begin
            acc_d = acc_q + add_val;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign value = acc_q;

endmodule

// File: rtl/ram_loader.sv
// RAM loader: fills the program RAM from a byte stream while the CPU is held
// off the bus, checks the stream checksum, then reads the RAM back and
// compares the readback sum against the stream sum.
// Ports:
//   CLK, RESET          - clock, synchronous active-high reset
//   START               - one-cycle load request (honoured in IDLE/DONE/FAIL)
//   IN_DATA, IN_VALID   - stream byte and its valid
//   IN_READY            - loader accepts a byte this cycle
//   RAM_ADDR, RAM_DIN   - RAM address and write data
//   RAM_RI              - RAM write enable
//   RAM_DOUT            - RAM read data, one cycle after RAM_ADDR
//   BUSY                - CPU halt / bus mux select
//   DONE                - image loaded and verified
//   ERR                 - 00 none, 01 checksum, 10 readback
//
// state  | meaning
// IDLE   | waiting for START
// LOAD   | accepting DEPTH image bytes, each written to RAM as accepted
// CHECK  | waiting for the checksum byte
// VERIFY | reading RAM back, DEPTH+1 cycles (one extra for read latency)
// DONE   | image good; waits for START
// FAIL   | ERR holds the cause; waits for START
module ram_loader #(
    parameter int DEPTH  = be8_pkg::RAM_DEPTH,
    parameter int ADDR_W = be8_pkg::RAM_ADDR_W,
    parameter int DATA_W = be8_pkg::DATA_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [DATA_W-1:0] RAM_DIN,
    output logic              RAM_RI,
    input  logic [DATA_W-1:0] RAM_DOUT,
    output logic              BUSY,
    output logic              DONE,
    output logic [1:0]        ERR
);

    import be8_pkg::*;

    // Counters carry one extra bit so they can reach DEPTH without wrapping.
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] CNT_END  = (ADDR_W+1)'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   wcnt_q, wcnt_d;
    logic [ADDR_W:0]   vcnt_q, vcnt_d;
    logic [1:0]        err_q, err_d;

    logic              sum_clr, sum_add;
    logic              rsum_clr, rsum_add;
    logic [DATA_W-1:0] sum_val, rsum_val;
    logic [DATA_W-1:0] rsum_nxt;
    logic [DATA_W-1:0] csum_chk;
    logic              accept;

    ram_loader_acc #(.DATA_W(DATA_W)) u_sum (
        .CLK     (CLK),
        .RESET   (RESET),
        .clr     (sum_clr),
        .add     (sum_add),
        .add_val (IN_DATA),
        .value   (sum_val)
    );

    ram_loader_acc #(.DATA_W(DATA_W)) u_rsum (
        .CLK     (CLK),
        .RESET   (RESET),
        .clr     (rsum_clr),
        .add     (rsum_add),
        .add_val (RAM_DOUT),
        .value   (rsum_val)
    );

    // IN_READY and RAM_RI are forced low during reset so a reset cycle can
    // never accept a byte or write the RAM.
    assign IN_READY = ~RESET & ((state_q == ST_LOAD) | (state_q == ST_CHECK));
    assign RAM_RI   = ~RESET & (state_q == ST_LOAD) & IN_VALID;
    assign accept   = IN_VALID & IN_READY;

    assign csum_chk = sum_val + IN_DATA;
    // The last readback add and the compare share a cycle, so compare
    // against the value the accumulator is about to take.
    assign rsum_nxt = rsum_val + RAM_DOUT;

    always_comb begin
        RAM_ADDR = '0;
        RAM_DIN  = '0;
        case (state_q)
            ST_LOAD: begin
                RAM_ADDR = wcnt_q[ADDR_W-1:0];
                RAM_DIN  = IN_DATA;
            end
            ST_VERIFY: begin
                RAM_ADDR = vcnt_q[ADDR_W-1:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        vcnt_d   = vcnt_q;
        err_d    = err_q;
        sum_clr  = 1'b0;
        sum_add  = 1'b0;
        rsum_clr = 1'b0;
        rsum_add = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (START) begin
                    state_d = ST_LOAD;
                    wcnt_d  = '0;
                    err_d   = ERR_NONE;
                    sum_clr = 1'b1;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    sum_add = 1'b1;
                    wcnt_d  = wcnt_q + 1'b1;
                    if (wcnt_q == CNT_LAST) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (accept) begin
                    if (csum_chk == '0) begin
                        state_d  = ST_VERIFY;
                        vcnt_d   = '0;
                        rsum_clr = 1'b1;
                    end else begin
                        state_d = ST_FAIL;
                        err_d   = ERR_CSUM;
                    end
                end
            end
            ST_VERIFY: begin
                vcnt_d = vcnt_q + 1'b1;
                // Read data lags the address by one cycle; nothing to add
                // on the first cycle.
                rsum_add = (vcnt_q != '0);
                if (vcnt_q == CNT_END) begin
                    if (rsum_nxt == sum_val) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FAIL;
                        err_d   = ERR_RDBK;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            vcnt_q  <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            vcnt_q  <= vcnt_d;
            err_q   <= err_d;
        end
    end

    assign BUSY = (state_q == ST_LOAD) | (state_q == ST_CHECK) | (state_q == ST_VERIFY);
    assign DONE = (state_q == ST_DONE);
    assign ERR  = err_q;

endmodule
